// File: rtl/sigmoid_pkg.sv
// rtl/sigmoid_pkg.sv - shared state encoding and default widths for the sigmoid scheduler
package sigmoid_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ARG  = 3'd1;
    localparam logic [2:0] ST_RES  = 3'd2;
    localparam logic [2:0] ST_ERR  = 3'd3;
    localparam logic [2:0] ST_FBK  = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        ARG  = ST_ARG,
        RES  = ST_RES,
        ERR  = ST_ERR,
        FBK  = ST_FBK
    } state_t;

    localparam int DEF_ARG_W = 16;
    localparam int DEF_RES_W = 8;
    localparam int DEF_FBK_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker, searches upward from ptr+1 with wrap
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    localparam int IW = $clog2(N);

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        // k = N lands back on ptr itself, so a lone re-requester still wins
        for (int k = 1; k <= N; k++) begin
            if (!valid && req[(int'(ptr) + k) % N]) begin
                valid                        = 1'b1;
                idx                          = IW'((int'(ptr) + k) % N);
                grant[(int'(ptr) + k) % N]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sigmoid_scheduler.sv
// rtl/sigmoid_scheduler.sv - time-shares one sigmoid unit among N neurons, one transaction at a time
module sigmoid_scheduler
    import sigmoid_pkg::*;
#(
    parameter int N     = 4,
    parameter int ARG_W = DEF_ARG_W,
    parameter int RES_W = DEF_RES_W,
    parameter int FBK_W = DEF_FBK_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 train,
    input  logic [N-1:0]         req_arg_stb,
    input  logic [N*ARG_W-1:0]   req_arg_dat,
    output logic [N-1:0]         req_arg_rdy,
    output logic [N-1:0]         req_res_stb,
    output logic [RES_W-1:0]     req_res_dat,
    input  logic [N-1:0]         req_res_rdy,
    input  logic [N-1:0]         req_err_stb,
    input  logic [N*ARG_W-1:0]   req_err_dat,
    output logic [N-1:0]         req_err_rdy,
    output logic [N-1:0]         req_fbk_stb,
    output logic [FBK_W-1:0]     req_fbk_dat,
    input  logic [N-1:0]         req_fbk_rdy,
    output logic                 act_en,
    output logic                 act_arg_stb,
    output logic [ARG_W-1:0]     act_arg_dat,
    input  logic                 act_arg_rdy,
    input  logic                 act_res_stb,
    input  logic [RES_W-1:0]     act_res_dat,
    output logic                 act_res_rdy,
    output logic                 act_err_stb,
    output logic [ARG_W-1:0]     act_err_dat,
    input  logic                 act_err_rdy,
    input  logic                 act_fbk_stb,
    input  logic [FBK_W-1:0]     act_fbk_dat,
    output logic                 act_fbk_rdy,
    output logic [$clog2(N)-1:0] gnt,
    output logic                 busy
);

    localparam int IW = $clog2(N);

    state_t          state, state_n;
    logic [IW-1:0]   ptr, ptr_n, gnt_n;
    logic [N-1:0]    gnt_oh, gnt_oh_n;
    logic            mode, mode_n;
    logic [N-1:0]    arb_grant;
    logic [IW-1:0]   arb_idx;
    logic            arb_valid;

    rr_arbiter #(.N(N)) u_arb (
        .req   (req_arg_stb),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= IW'(N - 1);
            gnt    <= '0;
            gnt_oh <= '0;
            mode   <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            gnt    <= gnt_n;
            gnt_oh <= gnt_oh_n;
            mode   <= mode_n;
        end
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        gnt_n       = gnt;
        gnt_oh_n    = gnt_oh;
        mode_n      = mode;
        req_arg_rdy = '0;
        req_res_stb = '0;
        req_res_dat = '0;
        req_err_rdy = '0;
        req_fbk_stb = '0;
        req_fbk_dat = '0;
        act_arg_stb = 1'b0;
        act_arg_dat = '0;
        act_res_rdy = 1'b0;
        act_err_stb = 1'b0;
        act_err_dat = '0;
        act_fbk_rdy = 1'b0;
        busy        = (state != IDLE);
        act_en      = mode && (state != IDLE);
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_n  = ARG;
                    ptr_n    = arb_idx;
                    gnt_n    = arb_idx;
                    gnt_oh_n = arb_grant;
                    mode_n   = train;
                end
            end
            ARG: begin
                act_arg_stb = req_arg_stb[gnt];
                act_arg_dat = req_arg_dat[int'(gnt)*ARG_W +: ARG_W];
                req_arg_rdy = gnt_oh & {N{act_arg_rdy}};
                if (act_arg_stb && act_arg_rdy) state_n = RES;
            end
            RES: begin
                req_res_stb = gnt_oh & {N{act_res_stb}};
                req_res_dat = act_res_dat;
                act_res_rdy = req_res_rdy[gnt];
                if (act_res_stb && act_res_rdy) state_n = mode ? ERR : IDLE;
            end
            ERR: begin
                act_err_stb = req_err_stb[gnt];
                act_err_dat = req_err_dat[int'(gnt)*ARG_W +: ARG_W];
                req_err_rdy = gnt_oh & {N{act_err_rdy}};
                if (act_err_stb && act_err_rdy) state_n = FBK;
            end
            FBK: begin
                req_fbk_stb = gnt_oh & {N{act_fbk_stb}};
                req_fbk_dat = act_fbk_dat;
                act_fbk_rdy = req_fbk_rdy[gnt];
                if (act_fbk_stb && act_fbk_rdy) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
